// File: rtl/camera_config_sequencer.sv
// camera_config_sequencer: boot-time OV7670 loader that resets the camera and writes a ROM table over SCCB
module camera_config_sequencer #(
    parameter int TABLE_DEPTH = 64,
    parameter logic [7:0] SLAVE_ID_RST = 8'h42,
    parameter int RESET_CYCLES = 50000,
    parameter int LONG_DELAY = 500000,
    parameter int GAP_CYCLES = 500,
    parameter int MAX_RETRY = 3,
    localparam int IDX_W = $clog2(TABLE_DEPTH)
) (
    input  logic             clk1,
    input  logic             rst1_n,
    input  logic [15:0]      d_in,
    input  logic             cs,
    input  logic [3:0]       addr1,
    input  logic             rd,
    input  logic             wr,
    output logic [15:0]      data_out,
    output logic [IDX_W-1:0] tbl_addr,
    input  logic [15:0]      tbl_data,
    output logic             sccb_req,
    output logic [7:0]       sccb_id,
    output logic [7:0]       sccb_reg,
    output logic [7:0]       sccb_data,
    input  logic             sccb_ack,
    input  logic             sccb_nack,
    output logic             cam_rst_n,
    output logic             config_done
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    typedef enum logic [3:0] {IDLE, CAMRST, FETCH, DECODE, ISSUE, GAP, DELAY, DONE, ERROR} state_t;
    state_t state, nxt;
    logic [31:0] cnt, lim;
    logic [IDX_W-1:0] idx;
    logic [RW-1:0] retry;
    logic [7:0] err_idx;
    logic [15:0] rdata;
    logic phase, abort_pend, reissue, busy, done, err, cnt_end, last;
    logic wr_ctrl, start, abort, ack, nack, unused;
    assign wr_ctrl = cs && wr && addr1 == 4'h0;
    assign abort = wr_ctrl && d_in[1];
    assign start = wr_ctrl && d_in[0] && !d_in[1];
    assign nack = sccb_nack;
    assign ack = sccb_ack && !sccb_nack;
    assign last = idx == IDX_W'(TABLE_DEPTH - 1);
    assign lim = state == CAMRST ? 32'(RESET_CYCLES - 1) :
                 state == DELAY  ? 32'(LONG_DELAY - 1) : 32'(GAP_CYCLES - 1);
    assign cnt_end = cnt == lim;
    assign tbl_addr = idx;
    assign unused = ^d_in[15:8];
    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) state <= IDLE;
        else state <= nxt;
    end
    // An abort seen in ISSUE is deferred so the SCCB transfer always finishes.
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERROR: nxt = start ? CAMRST : state;
            CAMRST: nxt = cnt_end && phase ? FETCH : CAMRST;
            FETCH: nxt = DECODE;
            DECODE: nxt = tbl_data == 16'hFFFF ? DONE : tbl_data == 16'hFFF0 ? DELAY : ISSUE;
            ISSUE: nxt = !(ack || nack) ? ISSUE : (abort_pend || abort) ? IDLE :
                         ack ? GAP : retry == RW'(MAX_RETRY) ? ERROR : GAP;
            GAP: nxt = !cnt_end ? GAP : reissue ? ISSUE : last ? DONE : FETCH;
            DELAY: nxt = !cnt_end ? DELAY : last ? DONE : FETCH;
            default: nxt = IDLE;
        endcase
        if (abort && state != ISSUE) nxt = IDLE;
    end
    always_comb begin
        busy = !(state == IDLE || state == DONE || state == ERROR);
        done = state == DONE;
        err = state == ERROR;
        config_done = done;
        sccb_req = state == ISSUE;
        cam_rst_n = !(state == CAMRST && !phase);
    end
    always_comb begin
        rdata = addr1 == 4'h1 ? {8'(idx), 5'b0, err, done, busy} :
                addr1 == 4'h2 ? {8'h0, sccb_id} :
                addr1 == 4'h3 ? {8'h0, err_idx} : 16'h0;
    end
    // phase 0 holds the camera in reset, phase 1 lets it settle before the first fetch
    always_ff @(posedge clk1 or negedge rst1_n) begin
        if (!rst1_n) begin
            cnt <= '0;
            phase <= 1'b0;
            idx <= '0;
            retry <= '0;
            reissue <= 1'b0;
            abort_pend <= 1'b0;
            sccb_reg <= 8'h0;
            sccb_data <= 8'h0;
            sccb_id <= SLAVE_ID_RST;
            err_idx <= 8'h0;
            data_out <= 16'h0;
        end else begin
            cnt <= (nxt != state || cnt_end) ? '0 : cnt + 32'd1;
            phase <= state == CAMRST && nxt == CAMRST && (phase || cnt_end);
            abort_pend <= state == ISSUE && nxt == ISSUE && (abort_pend || abort);
            if (state != CAMRST && nxt == CAMRST) begin
                idx <= '0;
                retry <= '0;
            end else if (nxt == FETCH && (state == GAP || state == DELAY)) begin
                idx <= idx + 1'b1;
            end
            if (state == ISSUE && (ack || nack)) begin
                reissue <= nack;
                retry <= nack ? retry + 1'b1 : '0;
            end
            if (state == DECODE && nxt == ISSUE) {sccb_reg, sccb_data} <= tbl_data;
            if (cs && wr && addr1 == 4'h2 && !busy) sccb_id <= d_in[7:0];
            if (state == ISSUE && nxt == ERROR) err_idx <= 8'(idx);
            if (cs && rd) data_out <= rdata;
        end
    end
endmodule
